bitonic_loader: RTL
===================

BITONIC_LOADER -- requirements
Module: bitonic_loader

Interface
REQ-001 Parameters: none; data width is fixed at 8 bits and group size is fixed at 8 words.
REQ-002 clk  input  1  rising-edge clock; all state changes on this edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 in_valid  input  1  upstream word present on in_data this cycle.
REQ-005 in_data  input  8  unsigned input word.
REQ-006 in_ready  output  1  block accepts in_data this cycle.
REQ-007 out_valid  output  1  number_out1..number_out8 hold a complete 8-word group.
REQ-008 out_ready  input  1  downstream sort stage consumes the group this cycle.
REQ-009 number_out1..number_out8  output  8 each  parallel group, feeding stage-1 sorter inputs number_in1..number_in8 directly.
REQ-010 fill_cnt  output  4  number of words currently stored, 0..8.

Function
REQ-011 Purpose: serial-to-parallel collector that gathers 8 consecutive accepted words into one group for the bitonic sorting network.
REQ-012 Input transfer: occurs on a rising edge where in_valid=1 and in_ready=1.
REQ-013 Output transfer: occurs on a rising edge where out_valid=1 and out_ready=1.
REQ-014 FSM states: COLLECT and FULL; reset state is COLLECT.
REQ-015 COLLECT behaviour: in_ready=1 and out_valid=0.
REQ-016 COLLECT slot order: the k-th accepted word (k=0..7) is registered into number_out(k+1), i.e. first word to number_out1 and eighth to number_out8.
REQ-017 COLLECT count: fill_cnt increments by 1 per input transfer.
REQ-018 COLLECT exit: on the transfer of the eighth word, the FSM enters FULL, fill_cnt becomes 8, and out_valid=1 from the next cycle.
REQ-019 COLLECT idle: cycles with in_valid=0 do not change any register (gaps are allowed anywhere in the group).
REQ-020 FULL behaviour: out_valid=1, and number_out1..8 are held stable until the output transfer.
REQ-021 FULL ready rule: in_ready = out_ready (combinational pass-through; no buffering beyond one group).
REQ-022 FULL with out_ready=0: no state change and no input accepted, regardless of in_valid.
REQ-023 FULL with out_ready=1 and in_valid=0: next state COLLECT, fill_cnt=0, out_valid=0.
REQ-024 FULL with out_ready=1 and in_valid=1 (simultaneous event): the group is released, in_data is written into number_out1, fill_cnt=1, next state COLLECT; zero-bubble back-to-back groups are thereby sustained.
REQ-025 Stale slots: after release, number_out2..8 retain the old values until overwritten; they are don't-care while out_valid=0.
REQ-026 Latency: out_valid rises 1 cycle after the eighth input transfer; minimum period is 8 cycles per group at full throughput.
REQ-027 fill_cnt: never exceeds 8 and never wraps.
REQ-028 Bounds: in_valid while in_ready=0 is ignored, and upstream holds the word.

Reset
REQ-029 While reset=1 at a rising edge: state is set to COLLECT, fill_cnt=0, out_valid=0, and number_out1..8 are all 8'h00.
REQ-030 While reset=1: in_ready=0, and any in_valid is ignored.
REQ-031 Mid-operation reset: reset asserted mid-group or in FULL discards the partial or complete group with no output transfer.
REQ-032 Post-reset acceptance: the first input transfer is possible on the first edge with reset=0.

Verification
REQ-033 Basic fill: after reset, feed 8'h10..8'h17 on 8 consecutive cycles with out_ready=0 -> out_valid=1 on cycle 9; number_out1=8'h10 ... number_out8=8'h17; fill_cnt=8; in_ready=0.
REQ-034 Backpressure hold: group held in FULL with out_ready=0 for 5 cycles while in_valid=1 and in_data=8'hAA -> outputs unchanged, and 8'hAA is not captured.
REQ-035 Back-to-back streaming: 16 words 8'h00..8'h0F with out_ready=1 held constantly -> two groups, released on cycles 9 and 17; the second group is 8'h08..8'h0F; no bubble.
REQ-036 Gapped input: words 8'hF0..8'hF7 with in_valid toggling 1,0,1,0... -> group complete after the 15th in_valid-cycle, with order preserved.
REQ-037 Mid-group reset: 3 words accepted, then reset for 1 cycle -> fill_cnt=0, all outputs 8'h00; the next 8 words form a clean group.
REQ-038 Simultaneous release and accept: FULL, out_ready=1, in_valid=1, in_data=8'h55 -> next cycle out_valid=0, fill_cnt=1, number_out1=8'h55.

Source files
------------

// File: rtl/bitonic_loader_if.sv
// bitonic_loader_if: serial word input, parallel 8-word group output and fill count
interface bitonic_loader_if;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_ready;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] number_out1, number_out2, number_out3, number_out4;
    logic [7:0] number_out5, number_out6, number_out7, number_out8;
    logic [3:0] fill_cnt;
    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, fill_cnt,
        input  number_out1, number_out2, number_out3, number_out4,
        input  number_out5, number_out6, number_out7, number_out8
    );
    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, fill_cnt,
        output number_out1, number_out2, number_out3, number_out4,
        output number_out5, number_out6, number_out7, number_out8
    );
endinterface

// File: rtl/bitonic_loader.sv
// bitonic_loader: gathers 8 accepted words into one parallel group for the sorter.
// A release and a new first word can share one edge, so groups stream without bubbles.
module bitonic_loader (
    input logic            clk,
    input logic            reset,
    bitonic_loader_if.slave bus
);
    typedef enum logic {COLLECT, FULL} state_t;
    state_t     r_state, w_next;
    logic [7:0] r_slot [8];
    logic [3:0] r_cnt;
    logic       w_in_xfer;
    logic       w_release;
    logic [2:0] w_idx;
    assign bus.in_ready  = !reset && (r_state == COLLECT || bus.out_ready);
    assign bus.out_valid = r_state == FULL;
    assign bus.fill_cnt  = r_cnt;
    assign w_in_xfer     = bus.in_valid && bus.in_ready;
    assign w_release     = r_state == FULL && bus.out_ready;
    // a word accepted on the release edge starts the next group in slot 0
    assign w_idx         = r_state == FULL ? 3'd0 : r_cnt[2:0];
    assign bus.number_out1 = r_slot[0];
    assign bus.number_out2 = r_slot[1];
    assign bus.number_out3 = r_slot[2];
    assign bus.number_out4 = r_slot[3];
    assign bus.number_out5 = r_slot[4];
    assign bus.number_out6 = r_slot[5];
    assign bus.number_out7 = r_slot[6];
    assign bus.number_out8 = r_slot[7];
    always_comb begin
        w_next = r_state;
        if (r_state == COLLECT && w_in_xfer && r_cnt == 4'd7)
            w_next = FULL;
        else if (w_release)
            w_next = COLLECT;
    end
    always_ff @(posedge clk) begin
        if (reset)
            r_state <= COLLECT;
        else
            r_state <= w_next;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt <= 4'd0;
            for (int i = 0; i < 8; i++)
                r_slot[i] <= 8'h00;
        end else begin
            if (w_release)
                r_cnt <= {3'b000, w_in_xfer};
            else if (w_in_xfer)
                r_cnt <= r_cnt + 4'd1;
            if (w_in_xfer)
                r_slot[w_idx] <= bus.in_data;
        end
    end
endmodule
